// File: rtl/redun_mont_pkg.sv
// Shared types and sizing helpers for the modular-squaring controller (msu_ctl).
package redun_mont_pkg;

    localparam int unsigned T_LEN    = 8;
    localparam int unsigned DAT_BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_SQ,
        UNLOAD,
        DONE
    } msu_ctl_state_t;

    function automatic int unsigned in_byts(input int unsigned dat_bits, input int unsigned t_len);
        return (dat_bits + 2 * t_len + 7) / 8;
    endfunction

    function automatic int unsigned out_byts(input int unsigned dat_bits, input int unsigned t_len);
        return (dat_bits + t_len + 7) / 8;
    endfunction

endpackage

// File: rtl/msu_ctl_ser.sv
// Serializes a packed little-endian result word into AXI-stream beats.
module msu_ctl_ser #(
    parameter int unsigned AXI_LEN  = 32,
    parameter int unsigned OUT_BYTS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [OUT_BYTS*8-1:0]  word,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXI_LEN-1:0]     m_axis_tdata,
    output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   done_c
);

    localparam int unsigned BEAT_BYTS = AXI_LEN / 8;
    localparam int unsigned NB_OUT    = (OUT_BYTS + BEAT_BYTS - 1) / BEAT_BYTS;
    localparam int unsigned SH_W      = NB_OUT * AXI_LEN;
    localparam int unsigned RW        = $clog2(OUT_BYTS + BEAT_BYTS + 1);

    logic [SH_W-1:0]      sh_q, sh_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic                 tvalid_d, tlast_d;
    logic [BEAT_BYTS-1:0] keep_cmp_c;
    logic [BEAT_BYTS-1:0] tkeep_d;

    assign m_axis_tdata = sh_q[AXI_LEN-1:0];
    assign done_c       = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    for (genvar k = 0; k < int'(BEAT_BYTS); k++) begin : g_keep
        assign keep_cmp_c[k] = (RW'(k) < rem_d);
    end

    // Next beat: load a fresh word, or advance only on an accepted beat so stalls hold everything.
    always_comb begin
        sh_d     = sh_q;
        rem_d    = rem_q;
        tvalid_d = m_axis_tvalid;
        if (load) begin
            sh_d     = SH_W'(word);
            rem_d    = RW'(OUT_BYTS);
            tvalid_d = 1'b1;
        end else if (m_axis_tvalid && m_axis_tready) begin
            sh_d     = sh_q >> AXI_LEN;
            rem_d    = m_axis_tlast ? '0 : rem_q - RW'(BEAT_BYTS);
            tvalid_d = !m_axis_tlast;
        end
        tlast_d = tvalid_d && (rem_d <= RW'(BEAT_BYTS));
        tkeep_d = {BEAT_BYTS{tvalid_d}} & keep_cmp_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q          <= '0;
            rem_q         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            sh_q          <= sh_d;
            rem_q         <= rem_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tkeep  <= tkeep_d;
            m_axis_tlast  <= tlast_d;
        end
    end

endmodule

// File: rtl/msu_ctl.sv
// Repeated-squaring controller: load {value,end_cnt,start_cnt}, square until cnt==end_cnt, emit {value,cnt}.
// Optional MSU_CTL_STOP_EN adds a 'stop' input that ends iteration early.
module msu_ctl #(
    parameter int unsigned AXI_LEN  = 32,
    parameter int unsigned T_LEN    = redun_mont_pkg::T_LEN,
    parameter int unsigned DAT_BITS = redun_mont_pkg::DAT_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ap_start,
`ifdef MSU_CTL_STOP_EN
    input  logic                  stop,
`endif
    output logic                  ap_done,
    output logic                  start_xfer,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [AXI_LEN-1:0]    s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]  s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AXI_LEN-1:0]    m_axis_tdata,
    output logic [AXI_LEN/8-1:0]  m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  sq_in_val,
    input  logic                  sq_in_rdy,
    output logic [DAT_BITS-1:0]   sq_in_dat,
    input  logic                  sq_out_val,
    input  logic [DAT_BITS-1:0]   sq_out_dat
);

    import redun_mont_pkg::*;

    localparam int unsigned BEAT_BYTS = AXI_LEN / 8;
    localparam int unsigned IN_BYTS   = in_byts(DAT_BITS, T_LEN);
    localparam int unsigned OUT_BYTS  = out_byts(DAT_BITS, T_LEN);
    localparam int unsigned IN_W      = IN_BYTS * 8;
    localparam int unsigned OUT_W     = OUT_BYTS * 8;
    localparam int unsigned NB_IN     = (IN_BYTS + BEAT_BYTS - 1) / BEAT_BYTS;
    localparam int unsigned BC_W      = $clog2(NB_IN + 1);
    localparam int unsigned VAL_LSB   = 2 * T_LEN;

    msu_ctl_state_t       state_q, state_d;
    logic [IN_W-1:0]      in_q, in_d;
    logic [IN_W-1:0]      in_byte_c, in_mask_c;
    logic [BC_W-1:0]      beat_q, beat_d;
    logic [T_LEN-1:0]     cnt_q, end_q;
    logic [DAT_BITS-1:0]  val_q;
    logic                 stop_d;
    logic                 start_xfer_d, ap_done_d, s_axis_tready_d, sq_in_val_d;
    logic                 ser_load_c, ser_done_c;

    assign cnt_q     = in_q[T_LEN-1:0];
    assign end_q     = in_q[2*T_LEN-1:T_LEN];
    assign val_q     = in_q[VAL_LSB +: DAT_BITS];
    assign sq_in_dat = val_q;

    // Beat n owns input bytes [n*BEAT_BYTS, (n+1)*BEAT_BYTS); bytes past IN_BYTS have no home and drop out.
    for (genvar j = 0; j < int'(IN_BYTS); j++) begin : g_in
        localparam int unsigned BI = j % BEAT_BYTS;
        localparam int unsigned BN = j / BEAT_BYTS;
        assign in_byte_c[8*j +: 8] = s_axis_tkeep[BI] ? s_axis_tdata[8*BI +: 8] : 8'h00;
        assign in_mask_c[8*j +: 8] = {8{beat_q == BC_W'(BN)}};
    end

`ifdef MSU_CTL_STOP_EN
    logic stop_q;

    // Sticky so a stop seen during WAIT_SQ still ends the run once the square returns.
    always_comb begin
        stop_d = 1'b0;
        if (state_q != IDLE)
            stop_d = stop_q || (stop && (state_q == RUN || state_q == WAIT_SQ));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stop_q <= 1'b0;
        else        stop_q <= stop_d;
    end
`else
    always_comb stop_d = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        beat_d     = beat_q;
        ser_load_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = LOAD;
                    in_d    = '0;
                    beat_d  = '0;
                end
            end
            LOAD: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    in_d = (in_q & ~in_mask_c) | (in_byte_c & in_mask_c);
                    if (beat_q != BC_W'(NB_IN)) beat_d = beat_q + BC_W'(1);
                    if (s_axis_tlast) state_d = RUN;
                end
            end
            RUN: begin
                if (sq_in_val && sq_in_rdy) begin
                    state_d = WAIT_SQ;
                end else if (cnt_q == end_q || stop_d) begin
                    state_d    = UNLOAD;
                    ser_load_c = 1'b1;
                end
            end
            WAIT_SQ: begin
                if (sq_out_val) begin
                    in_d[VAL_LSB +: DAT_BITS] = sq_out_dat;
                    in_d[T_LEN-1:0]           = cnt_q + T_LEN'(1);
                    state_d                   = RUN;
                end
            end
            UNLOAD: begin
                if (ser_done_c) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_xfer_d    = (state_q == IDLE) && (state_d == LOAD);
        ap_done_d       = (state_d == DONE);
        s_axis_tready_d = (state_d == LOAD);
        sq_in_val_d     = (state_d == RUN) && !stop_d
                          && (in_d[T_LEN-1:0] != in_d[2*T_LEN-1:T_LEN]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_q          <= '0;
            beat_q        <= '0;
            start_xfer    <= 1'b0;
            ap_done       <= 1'b0;
            s_axis_tready <= 1'b0;
            sq_in_val     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_q          <= in_d;
            beat_q        <= beat_d;
            start_xfer    <= start_xfer_d;
            ap_done       <= ap_done_d;
            s_axis_tready <= s_axis_tready_d;
            sq_in_val     <= sq_in_val_d;
        end
    end

    msu_ctl_ser #(
        .AXI_LEN  (AXI_LEN),
        .OUT_BYTS (OUT_BYTS)
    ) u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ser_load_c),
        .word          (OUT_W'({val_q, cnt_q})),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .done_c        (ser_done_c)
    );

endmodule

// File: tb/tb_msu_ctl.sv
// Directed bench for msu_ctl with a stub squarer (result = operand + 1, five cycles later).
module tb_msu_ctl;

    localparam int unsigned AXI_LEN  = 32;
    localparam int unsigned T_LEN    = 8;
    localparam int unsigned DAT_BITS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, start_xfer;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        sq_in_val, sq_in_rdy;
    logic [31:0] sq_in_dat;
    logic        sq_out_val = 1'b0;
    logic [31:0] sq_out_dat = '0;
`ifdef MSU_CTL_STOP_EN
    logic        stop = 1'b0;
`endif

    logic        sq_busy = 1'b0;
    int          sq_tmr = 0;
    logic [31:0] sq_res = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, xfer_cnt = 0, hs_cnt = 0;

    always #5 clk = ~clk;

    msu_ctl #(.AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .DAT_BITS(DAT_BITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ap_start      (ap_start),
`ifdef MSU_CTL_STOP_EN
        .stop          (stop),
`endif
        .ap_done       (ap_done),
        .start_xfer    (start_xfer),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .sq_in_val     (sq_in_val),
        .sq_in_rdy     (sq_in_rdy),
        .sq_in_dat     (sq_in_dat),
        .sq_out_val    (sq_out_val),
        .sq_out_dat    (sq_out_dat)
    );

    // Stub squarer is never reset, so a stale result can land after a DUT reset.
    assign sq_in_rdy = !sq_busy;
    always @(posedge clk) begin
        sq_out_val <= 1'b0;
        if (sq_busy) begin
            if (sq_tmr == 1) begin
                sq_out_val <= 1'b1;
                sq_out_dat <= sq_res;
                sq_busy    <= 1'b0;
            end
            sq_tmr <= sq_tmr - 1;
        end else if (sq_in_val && sq_in_rdy) begin
            sq_busy <= 1'b1;
            sq_res  <= sq_in_dat + 32'd1;
            sq_tmr  <= 5;
        end
    end

    always @(posedge clk) begin
        if (ap_done)                done_cnt <= done_cnt + 1;
        if (start_xfer)             xfer_cnt <= xfer_cnt + 1;
        if (sq_in_val && sq_in_rdy) hs_cnt   <= hs_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All helpers are entered and left right after a falling edge.
    task automatic pulse_start();
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] st, input logic [7:0] en, input logic [31:0] val,
                            input int nbeats, output bit to);
        logic [95:0] p;
        int n;
        p  = {32'hDEADBEEF, 16'hA5A5, val, en, st};
        to = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(p >> (32 * b));
            s_axis_tkeep  = 4'hF;
            s_axis_tlast  = (b == nbeats - 1);
            n = 0;
            while (!s_axis_tready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!s_axis_tready) to = 1'b1;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic recv_pkt(input bit toggle, output logic [63:0] word, output logic [7:0] keeps,
                            output int nb, output int viol, output bit to);
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        bit          held, ph;
        word = '0; keeps = '0; nb = 0; viol = 0; to = 1'b1;
        held = 1'b0; ph = 1'b1; pd = '0; pk = '0; pl = 1'b0;
        for (int c = 0; c < 400 && to; c++) begin
            m_axis_tready = toggle ? ph : 1'b1;
            ph = !ph;
            if (m_axis_tvalid) begin
                if (held && (m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl))
                    viol++;
                pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
                held = !m_axis_tready;
                if (m_axis_tready) begin
                    if (nb < 2) begin
                        word  = word | (64'(m_axis_tdata) << (32 * nb));
                        keeps = keeps | (8'(m_axis_tkeep) << (4 * nb));
                    end
                    nb++;
                    if (m_axis_tlast) to = 1'b0;
                end
            end
            @(negedge clk);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ap_done, start_xfer, s_axis_tready, m_axis_tvalid, m_axis_tlast, sq_in_val} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ap_done, start_xfer, s_axis_tready, m_axis_tvalid, m_axis_tlast, sq_in_val});
        end
        checks++;
        if ({m_axis_tdata, m_axis_tkeep} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {m_axis_tdata, m_axis_tkeep});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full run plus result checks shared by the packet scenarios; each caller names its case.
    task automatic run_case(input string name, input logic [7:0] st, input logic [7:0] en,
                            input logic [31:0] val, input int nbeats, input bit toggle,
                            input int exp_hs, input logic [7:0] exp_cnt, input logic [31:0] exp_val);
        logic [63:0] word, exp_word;
        logic [7:0]  keeps;
        int nb, viol, hs0, dn0, xf0;
        bit to_s, to_r;
        hs0 = hs_cnt; dn0 = done_cnt; xf0 = xfer_cnt;
        exp_word = 64'({exp_val, exp_cnt});
        pulse_start();
        send_pkt(st, en, val, nbeats, to_s);
        recv_pkt(toggle, word, keeps, nb, viol, to_r);
        repeat (2) @(negedge clk);
        checks++;
        if (to_s || to_r) begin
            errors++;
            $display("FAIL %s_timeout: got send=%0d recv=%0d expected 0 0", name, to_s, to_r);
        end
        checks++;
        if (word !== exp_word) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, word, exp_word);
        end
        checks++;
        if (keeps !== 8'h1F || nb != 2) begin
            errors++;
            $display("FAIL %s_beats: got keep=%h beats=%0d expected keep=1f beats=2", name, keeps, nb);
        end
        checks++;
        if (hs_cnt - hs0 != exp_hs) begin
            errors++;
            $display("FAIL %s_squarings: got %0d expected %0d", name, hs_cnt - hs0, exp_hs);
        end
        checks++;
        if (done_cnt - dn0 != 1 || xfer_cnt - xf0 != 1) begin
            errors++;
            $display("FAIL %s_pulses: got done=%0d xfer=%0d expected 1 1", name,
                     done_cnt - dn0, xfer_cnt - xf0);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s_stall_stable: got %0d changes expected 0", name, viol);
        end
    endtask

    task automatic test_basic();
        logic [63:0] word;
        logic [7:0]  keeps;
        int nb, viol, dn0, xf0;
        bit to_s, to_r;
        dn0 = done_cnt; xf0 = xfer_cnt;
        pulse_start();
        checks++;
        if (start_xfer !== 1'b1 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL start_xfer_pulse: got xfer=%b tready=%b expected 1 1", start_xfer, s_axis_tready);
        end
        send_pkt(8'd0, 8'd10, 32'd2, 2, to_s);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        recv_pkt(1'b0, word, keeps, nb, viol, to_r);
        repeat (2) @(negedge clk);
        checks++;
        if (to_s || to_r || word !== 64'h0000_0000_0000_0C0A) begin
            errors++;
            $display("FAIL basic_result: got %h timeouts=%0d%0d expected 0000000000000c0a", word, to_s, to_r);
        end
        checks++;
        if (done_cnt - dn0 != 1 || xfer_cnt - xf0 != 1) begin
            errors++;
            $display("FAIL basic_ignore_start: got done=%0d xfer=%0d expected 1 1",
                     done_cnt - dn0, xfer_cnt - xf0);
        end
        checks++;
        if (ap_done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after: got done=%b tvalid=%b expected 0 0", ap_done, m_axis_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        int n, dn0, extra;
        dn0 = 0; extra = 0;
        n = hs_cnt;
        pulse_start();
        begin
            bit to_s;
            send_pkt(8'd0, 8'd10, 32'd2, 2, to_s);
        end
        for (int c = 0; c < 100 && hs_cnt == n; c++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready, sq_in_val, m_axis_tvalid, ap_done, m_axis_tlast} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got %b expected 00000",
                     {s_axis_tready, sq_in_val, m_axis_tvalid, ap_done, m_axis_tlast});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case("reset_mid", 8'd0, 8'd2, 32'd4, 2, 1'b0, 2, 8'd2, 32'd6);
        dn0 = done_cnt;
        for (int c = 0; c < 30; c++) begin
            if (m_axis_tvalid) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0 || done_cnt != dn0) begin
            errors++;
            $display("FAIL reset_mid_no_extra: got tvalid_cycles=%0d done=%0d expected 0 0",
                     extra, done_cnt - dn0);
        end
    endtask

`ifdef MSU_CTL_STOP_EN
    task automatic test_stop();
        logic [63:0] word;
        logic [7:0]  keeps;
        logic [7:0]  cnt;
        int nb, viol, hs0;
        bit to_s, to_r;
        hs0 = hs_cnt;
        pulse_start();
        send_pkt(8'd0, 8'd100, 32'd10, 2, to_s);
        for (int c = 0; c < 200 && hs_cnt - hs0 < 3; c++) @(negedge clk);
        stop = 1'b1;
        recv_pkt(1'b0, word, keeps, nb, viol, to_r);
        stop = 1'b0;
        cnt = word[7:0];
        checks++;
        if (to_s || to_r || !(cnt == 8'd3 || cnt == 8'd4) || word[39:8] !== 32'd10 + 32'(cnt)) begin
            errors++;
            $display("FAIL stop_result: got cnt=%0d value=%0d expected cnt 3 or 4 value=10+cnt",
                     cnt, word[39:8]);
        end
        checks++;
        if (hs_cnt - hs0 != int'(cnt)) begin
            errors++;
            $display("FAIL stop_squarings: got %0d expected %0d", hs_cnt - hs0, cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        run_case("zero_iter",     8'd5,   8'd5, 32'd7,        2, 1'b0, 0, 8'd5, 32'd7);
        run_case("wrap",          8'd254, 8'd1, 32'd0,        2, 1'b0, 3, 8'd1, 32'd3);
        run_case("early_tlast",   8'd3,   8'd3, 32'h1234BEEF, 1, 1'b0, 0, 8'd3, 32'h0000BEEF);
        run_case("extra_beats",   8'd1,   8'd2, 32'h100,      3, 1'b0, 1, 8'd2, 32'h101);
        run_case("backpressure",  8'd0,   8'd10, 32'd2,       2, 1'b1, 10, 8'd10, 32'd12);
        test_reset_mid();
`ifdef MSU_CTL_STOP_EN
        test_stop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
